// File: rtl/plot_framebuffer_sink.sv
// Pixel-plot sink: buffers plot commands in a small FIFO and writes them into an on-chip
// WIDTH x HEIGHT colour framebuffer, with a coherent single-pixel read-back port.
module plot_framebuffer_sink #(
   parameter int unsigned       WIDTH        = 160,
   parameter int unsigned       HEIGHT       = 120,
   parameter int unsigned       X_W          = 8,
   parameter int unsigned       Y_W          = 7,
   parameter int unsigned       C_W          = 3,
   parameter int unsigned       FIFO_DEPTH   = 4,
   parameter logic [C_W-1:0]    CLEAR_COLOUR = '0
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic [X_W-1:0]                in_x,
   input  logic [Y_W-1:0]                in_y,
   input  logic [C_W-1:0]                in_colour,
   input  logic                          in_plot,
   output logic                          in_ready,
   input  logic                          rd_req,
   input  logic [X_W-1:0]                rd_x,
   input  logic [Y_W-1:0]                rd_y,
   output logic                          rd_ready,
   output logic                          rd_valid,
   output logic [C_W-1:0]                rd_colour,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    drop_count
);

   localparam int unsigned NPIX   = WIDTH * HEIGHT;
   localparam int unsigned ADDR_W = $clog2(NPIX);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] c;
   } plot_t;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] clr_addr;
   plot_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level_nx;
   plot_t             head;
   logic              head_ok, rd_ok;
   logic              push, pop, rd_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [C_W-1:0]    mem_wdata;
   logic [C_W-1:0]    fb [NPIX];

   function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (32'(x) < WIDTH) && (32'(y) < HEIGHT);
   endfunction

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
      return ADDR_W'(32'(y) * WIDTH + 32'(x));
   endfunction

   // Arbitration of the single memory port: sweep, then FIFO pop, then read.
   always_comb begin
      state_nx  = state;
      push      = 1'b0;
      pop       = 1'b0;
      rd_en     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = clr_addr;
      mem_wdata = CLEAR_COLOUR;
      head      = fifo_mem[rd_ptr];
      head_ok   = in_range(head.x, head.y);
      rd_ok     = in_range(rd_x, rd_y);
      case (state)
         S_CLEAR: begin
            mem_we = 1'b1;
            if (clr_addr == ADDR_LAST) state_nx = S_RUN;
         end
         S_RUN: begin
            push = in_plot & in_ready;
            if (fifo_level != '0) begin
               pop = 1'b1;
               if (head_ok) begin
                  mem_we    = 1'b1;
                  mem_addr  = pix_addr(head.x, head.y);
                  mem_wdata = head.c;
               end
            end else if (rd_req & rd_ready) begin
               rd_en = 1'b1;
               if (rd_ok) mem_addr = pix_addr(rd_x, rd_y);
            end
         end
         default: state_nx = S_CLEAR;
      endcase
      level_nx = fifo_level + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= S_CLEAR;
         clr_addr   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         in_ready   <= 1'b0;
         rd_ready   <= 1'b0;
         busy       <= 1'b1;
         rd_valid   <= 1'b0;
         rd_colour  <= '0;
         drop_count <= '0;
      end else begin
         state      <= state_nx;
         if (state == S_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_level <= level_nx;
         // Handshake flags are registered from next-cycle state and occupancy.
         in_ready   <= (state_nx == S_RUN) && (level_nx != LVL_FULL);
         rd_ready   <= (state_nx == S_RUN) && (level_nx == '0);
         busy       <= (state_nx == S_CLEAR) || (level_nx != '0);
         rd_valid   <= rd_en;
         if (rd_en) rd_colour <= rd_ok ? fb[mem_addr] : CLEAR_COLOUR;
         if (pop && !head_ok && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= '{x: in_x, y: in_y, c: in_colour};
   end

   always_ff @(posedge clock) begin
      if (resetn && mem_we) fb[mem_addr] <= mem_wdata;
   end

endmodule
